// File: rtl/pc_fetch_if.sv
// Fetch-control bundle between the top level / PC_LUT and pc_fetch_ctrl.
// The slave modport is the fetch controller's view.
interface pc_fetch_if #(
    parameter int D = 10,
    parameter int C = 16
);
    logic         start;
    logic         stall;
    logic         jump_en;
    logic         branch_en;
    logic         branch_cond;
    logic [3:0]   jump_idx;
    logic [D-1:0] lut_target;
    logic         halt_req;
    logic [3:0]   lut_addr;
    logic [D-1:0] prog_ctr;
    logic         fetch_valid;
    logic         done;
    logic [C-1:0] instr_count;

    modport master (
        output start, stall, jump_en, branch_en, branch_cond,
        output jump_idx, lut_target, halt_req,
        input  lut_addr, prog_ctr, fetch_valid, done, instr_count
    );

    modport slave (
        input  start, stall, jump_en, branch_en, branch_cond,
        input  jump_idx, lut_target, halt_req,
        output lut_addr, prog_ctr, fetch_valid, done, instr_count
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch control: sequential stepping, LUT-based
// redirects with a one-cycle squash bubble, and start/halt/done handshake.
module pc_fetch_ctrl #(
    parameter int D        = 10,
    parameter int START_PC = 0,
    parameter int C        = 16
) (
    input  logic      clk,
    input  logic      reset,
    pc_fetch_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        BUBBLE,
        HALTED
    } state_t;

    localparam logic [D-1:0] PC_INIT = D'(START_PC);

    state_t       state_q, state_d;
    logic [D-1:0] pc_q, pc_d;
    logic         done_q, done_d;
    logic [C-1:0] cnt_q, cnt_d;
    logic         redirect;
    logic [C-1:0] cnt_inc;

    assign redirect = bus.jump_en | (bus.branch_en & bus.branch_cond);
    // Retired-instruction counter sticks at its maximum instead of wrapping.
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + C'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, HALTED: begin
                if (bus.start) begin
                    state_d = RUN;
                    pc_d    = PC_INIT;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (!bus.stall) begin
                    cnt_d = cnt_inc;
                    if (bus.halt_req) begin
                        state_d = HALTED;
                        done_d  = 1'b1;
                    end else if (redirect) begin
                        state_d = BUBBLE;
                        pc_d    = bus.lut_target;
                    end else begin
                        pc_d = pc_q + D'(1);
                    end
                end
            end
            BUBBLE: begin
                if (!bus.stall) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= PC_INIT;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.lut_addr    = bus.jump_idx;
    assign bus.prog_ctr    = pc_q;
    assign bus.fetch_valid = (state_q == RUN);
    assign bus.done        = done_q;
    assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: each driven cycle queues the
// expected post-edge outputs, a monitor pops and compares them.
module tb_pc_fetch_ctrl;
    localparam int D = 10;
    localparam int C = 16;

    typedef struct {
        logic [D-1:0] pc;
        logic         fv;
        logic         dn;
        logic [C-1:0] cnt;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];

    pc_fetch_if #(.D(D), .C(C)) bus ();

    pc_fetch_ctrl #(.D(D), .START_PC(0), .C(C)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("prog_ctr", 32'(bus.prog_ctr), 32'(e.pc));
            chk("fetch_valid", 32'(bus.fetch_valid), 32'(e.fv));
            chk("done", 32'(bus.done), 32'(e.dn));
            chk("instr_count", 32'(bus.instr_count), 32'(e.cnt));
        end
    end

    task automatic clr();
        reset           = 1'b0;
        bus.start       = 1'b0;
        bus.stall       = 1'b0;
        bus.jump_en     = 1'b0;
        bus.branch_en   = 1'b0;
        bus.branch_cond = 1'b0;
        bus.jump_idx    = 4'd0;
        bus.lut_target  = '0;
        bus.halt_req    = 1'b0;
    endtask

    // Inputs are already set; queue the outputs expected after the next edge.
    task automatic tick(input int pc, input bit fv, input bit dn, input int cnt);
        exp_t e;
        e.pc  = D'(pc);
        e.fv  = fv;
        e.dn  = dn;
        e.cnt = C'(cnt);
        sb.push_back(e);
        @(negedge clk);
        clr();
    endtask

    task automatic jump(input logic [3:0] idx, input int tgt);
        bus.jump_en    = 1'b1;
        bus.jump_idx   = idx;
        bus.lut_target = D'(tgt);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clr();
        @(negedge clk);

        reset = 1'b1; tick(0, 0, 0, 0);
        reset = 1'b1; tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        bus.start = 1'b1; tick(0, 1, 0, 0);
        for (int i = 1; i <= 5; i++) tick(i, 1, 0, i);

        reset = 1'b1; tick(0, 0, 0, 0);
        bus.start = 1'b1; tick(0, 1, 0, 0);
        for (int i = 1; i <= 3; i++) tick(i, 1, 0, i);

        jump(4'd2, 41);
        #1 chk("lut_addr", 32'(bus.lut_addr), 32'd2);
        tick(41, 0, 0, 4);
        jump(4'd5, 7);
        bus.halt_req = 1'b1;
        tick(41, 1, 0, 4);
        tick(42, 1, 0, 5);

        bus.branch_en  = 1'b1;
        bus.lut_target = D'(500);
        tick(43, 1, 0, 6);

        bus.branch_en   = 1'b1;
        bus.branch_cond = 1'b1;
        bus.jump_idx    = 4'd9;
        bus.lut_target  = D'(99);
        #1 chk("lut_addr_br", 32'(bus.lut_addr), 32'd9);
        tick(99, 0, 0, 7);
        tick(99, 1, 0, 7);
        tick(100, 1, 0, 8);

        jump(4'd15, 1023);
        bus.branch_en   = 1'b1;
        bus.branch_cond = 1'b1;
        tick(1023, 0, 0, 9);
        tick(1023, 1, 0, 9);
        tick(0, 1, 0, 10);
        tick(1, 1, 0, 11);

        jump(4'd1, 2);
        tick(2, 0, 0, 12);
        tick(2, 1, 0, 12);

        for (int i = 0; i < 3; i++) begin
            jump(4'd3, 7);
            bus.stall = 1'b1;
            tick(2, 1, 0, 12);
        end
        jump(4'd3, 7);
        tick(7, 0, 0, 13);
        jump(4'd3, 20);
        bus.stall = 1'b1;
        tick(7, 0, 0, 13);
        tick(7, 1, 0, 13);

        jump(4'd4, 300);
        bus.halt_req = 1'b1;
        tick(7, 0, 1, 14);
        jump(4'd4, 300);
        bus.halt_req = 1'b1;
        tick(7, 0, 1, 14);

        bus.start = 1'b1; tick(0, 1, 0, 0);
        tick(1, 1, 0, 1);
        bus.start = 1'b1; tick(2, 1, 0, 2);
        jump(4'd6, 50);
        reset = 1'b1;
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);

        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Program-counter and fetch-control stage directly downstream of the PC_LUT jump-target table.
- Holds the D-bit program counter and steps it sequentially.
- Drives the 4-bit LUT index from the current instruction's jump field and loads the returned absolute target on a taken jump or branch.
- Manages start, halt and done handshake with the testbench/top level, plus a one-cycle squash bubble after every redirect.

Parameters:
D, 10, program counter and jump-target width; matches the PC_LUT target width.
START_PC, 0, value loaded into prog_ctr on start.
C, 16, width of the retired-instruction counter.

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  single-cycle pulse that begins program execution.
stall  in  1  freezes all state for the cycle.
jump_en  in  1  unconditional jump decoded from the current instruction.
branch_en  in  1  conditional branch decoded from the current instruction.
branch_cond  in  1  branch flag from the ALU/flag register.
jump_idx  in  4  LUT index field of the current instruction.
lut_target  in  D  target returned by PC_LUT; combinational from lut_addr.
halt_req  in  1  halt instruction decoded.
lut_addr  out  4  index to PC_LUT; equals jump_idx combinationally.
prog_ctr  out  D  current fetch address.
fetch_valid  out  1  current instruction is architecturally live (not squashed).
done  out  1  program finished; held high until next start.
instr_count  out  C  count of retired (valid, unstalled) instructions.

Behaviour:
- States: IDLE, RUN, BUBBLE, HALTED. Encoding is free.
- Reset values: state=IDLE, prog_ctr=START_PC, fetch_valid=0, done=0, instr_count=0.
- Reset overrides every other input in the same cycle, including mid-RUN.
- IDLE: prog_ctr holds. start → RUN, prog_ctr<=START_PC, instr_count<=0. All other inputs ignored.
- HALTED:
  - done=1.
  - start → RUN, prog_ctr<=START_PC, done<=0, instr_count<=0.
  - All other inputs ignored.
- RUN:
  - fetch_valid=1 combinationally.
  - Per-cycle priority: stall > halt_req > redirect > increment.
  - stall=1: prog_ctr, state and instr_count hold. Other inputs ignored.
  - halt_req=1:
    - → HALTED next cycle with done<=1.
    - prog_ctr holds.
    - instr_count increments (halt instruction retires).
    - Any jump or branch in the same cycle is ignored.
  - Redirect is taken when jump_en=1, or when branch_en=1 and branch_cond=1.
    - Taken: prog_ctr<=lut_target, → BUBBLE, instr_count increments.
    - jump_en and branch_en both high: treated as a single jump (same LUT target).
  - Otherwise: prog_ctr<=prog_ctr+1, mod 2^D. 2^D−1 wraps to 0 with no flag.
  - instr_count increments in every RUN cycle not stalled; it saturates at 2^C−1.
- BUBBLE:
  - fetch_valid=0.
  - jump_en, branch_en and halt_req are ignored (squashed instruction).
  - prog_ctr does not advance; the target is fetched next cycle. No count increment.
  - stall=1 holds BUBBLE. Otherwise → RUN next cycle.
- A redirect to the address prog_ctr+1 still inserts the bubble.
- start in RUN or BUBBLE is ignored.
- lut_addr=jump_idx in all states. lut_target is sampled only on a taken redirect.
- Latency:
  - Redirect: target appears on prog_ctr 1 cycle after the taken edge; fetch_valid returns 1 cycle later.
  - Halt: done rises 1 cycle after the halt_req cycle.
- All outputs are registered except fetch_valid and lut_addr, which are decoded from registered state/inputs.

Test Plan:
- Reset, start pulse, 5 idle-decode cycles → prog_ctr 0,1,2,3,4,5; fetch_valid=1; instr_count=5.
- At prog_ctr=3, jump_en=1, jump_idx=2, lut_target=41:
  - lut_addr=2.
  - Next cycle prog_ctr=41 with fetch_valid=0.
  - Then fetch_valid=1 and prog_ctr=42 on the following increment.
- branch_en=1 with branch_cond=0 → prog_ctr+1, no bubble.
- branch_en=1 with branch_cond=1, lut_target=99 → prog_ctr=99, one bubble.
- Redirect to lut_target=1023, then run 2 cycles → prog_ctr 1023, 0; no error.
- stall=1 for 3 cycles with jump_en=1:
  - prog_ctr and instr_count frozen.
  - Jump taken only on the first unstalled cycle.
- halt_req and jump_en together at prog_ctr=7:
  - done=1 next cycle; prog_ctr stays 7.
  - Later start restarts at START_PC with done=0 and instr_count=0.
  - reset asserted mid-RUN returns to IDLE with all outputs at reset values.
